// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle restoring radix-2 signed/unsigned divider for the EX stage
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| finishes through the divide-by-zero timing path.
module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_t;

    localparam logic [DATA_W-1:0] ONE   = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO  = '0;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_1 = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  op1_neg, op2_neg;
    logic [DATA_W-1:0]     abs1, abs2;
    logic [DATA_W:0]       shifted, diff;
    logic [DATA_W-1:0]     quo_fix, rem_fix;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign abs1    = op1_neg ? (~opdata1_i + ONE) : opdata1_i;
    assign abs2    = op2_neg ? (~opdata2_i + ONE) : opdata2_i;

    // Partial remainder < divisor, so one extra bit is enough to detect the borrow.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign quo_fix = negq_q ? (~quo_q + ONE) : quo_q;
    assign rem_fix = negr_q ? (~rem_q + ONE) : rem_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            S_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == ZERO) begin
                        state_d = S_BYZERO;
                        rem_d   = '0;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs1 < abs2) begin
                        state_d = S_BYZERO;
                        rem_d   = opdata1_i;
                    end
`endif
                    else begin
                        state_d = S_ON;
                        rem_d   = '0;
                        quo_d   = abs1;
                        dvs_d   = abs2;
                        negq_d  = op1_neg ^ op2_neg;
                        negr_d  = op1_neg;
                        cnt_d   = '0;
                    end
                end
            end
            S_BYZERO: begin
                state_d  = S_END;
                result_d = {rem_q, ZERO};
                ready_d  = 1'b1;
            end
            S_ON: begin
                if (cnt_q == LAST) begin
                    state_d  = S_END;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    rem_d = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
                    cnt_d = cnt_q + CNT_1;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = S_FREE;
        endcase

        if (annul_i && state_q != S_FREE) begin
            state_d  = S_FREE;
            ready_d  = 1'b0;
            result_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed self-checking bench for ex_div
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, stallreq;

    int total = 0;
    int bad   = 0;

    ex_div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int edges  = 0;
        int stalls = 0;
        @(negedge clk);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
        while (!ready && edges < 100) begin
            #1;
            if (stallreq) stalls++;
            @(posedge clk);
            edges++;
            #1;
        end
        chk({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_stall"}, 64'(stalls), 64'(exp_lat));
        @(negedge clk);
        chk({tag, "_hold_nostall"}, 64'(stallreq), 64'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        chk({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        int early_lat;
        int seen;
        rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 64'(ready), 64'd0);
        chk("rst_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          34, {32'd2, 32'd14});
        run_div("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          34, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   34, {32'd1, 32'hFFFFFFFD});
        run_div("div_m100_m7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   34, {32'hFFFFFFFE, 32'd14});
        run_div("div_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   34, {32'd0, 32'h80000000});
        run_div("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          34, {32'd0, 32'hFFFFFFFF});
        run_div("divu_5_0",     1'b0, 32'd5,          32'd0,           2, 64'd0);
`ifdef DIV_EARLY_OUT_EN
        early_lat = 2;
`else
        early_lat = 34;
`endif
        run_div("divu_3_10",    1'b0, 32'd3,          32'd10, early_lat, {32'd3, 32'd0});

        // annul part-way through the iterations
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1;
        chk("annul_nostall", 64'(stallreq), 64'd0);
        @(posedge clk);
        #1;
        chk("annul_rdy", 64'(ready), 64'd0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        chk("annul_quiet", 64'(seen), 64'd0);
        run_div("divu_9_3",     1'b0, 32'd9,          32'd3,          34, {32'd0, 32'd3});

        // reset in the middle of an iteration
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("midon_stall", 64'(stallreq), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midon_rst_rdy", 64'(ready), 64'd0);
        chk("midon_rst_res", result, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        run_div("divu_1000_3",  1'b0, 32'd1000,       32'd3,          34, {32'd1, 32'd333});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
